spectrum_frame_fifo: RTL
========================

SPECTRUM_FRAME_FIFO -- requirements
Module: spectrum_frame_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 9, bits per data word.
REQ-002 SHALL have parameter DATA_POINTS, default 5, words per frame.
REQ-003 SHALL have parameter DEPTH_LOG2, default 3, log2 of frame capacity (DEPTH = 2**DEPTH_LOG2).
REQ-004 SHALL have port eth_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port sclr_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port data_in  input  DATA_POINTS x WIDTH  unpacked array, one full frame.
REQ-007 SHALL have port wr_valid  input  1  frame on data_in offered.
REQ-008 SHALL have port wr_ready  output  1  a frame can be accepted.
REQ-009 SHALL have port data_out  output  WIDTH  current output word.
REQ-010 SHALL have port word_idx  output  $clog2(DATA_POINTS)  index of data_out within its frame.
REQ-011 SHALL have port last  output  1  data_out is the final word of its frame.
REQ-012 SHALL have port rd_valid  output  1  data_out valid.
REQ-013 SHALL have port rd_ready  input  1  consumer takes data_out.
REQ-014 SHALL have port empty, full  output  1 each  frame-level status.
REQ-015 SHALL have port fill_count  output  DEPTH_LOG2+1  stored frames, including a partially read frame.
REQ-016 SHALL have port overflow_count  output  16  dropped-frame counter (see Configuration).

Function
REQ-017 SHALL accept a frame when wr_valid && wr_ready; all DATA_POINTS words are stored in one cycle at write pointer; data_in is ignored otherwise.
REQ-018 SHALL drive wr_ready = !full, from registered state only, with no dependence on rd_ready in the same cycle.
REQ-019 SHALL drive rd_valid = !empty; an accepted frame first appears on data_out the cycle after acceptance (latency 1).
REQ-020 SHALL drive data_out = stored[read pointer][word_idx]; data_out SHALL be 0 when empty.
REQ-021 SHALL advance on each rd_valid && rd_ready transfer: word_idx increments; when word_idx == DATA_POINTS-1, word_idx returns to 0, the read pointer increments and the frame is retired.
REQ-022 SHALL assert last = rd_valid && (word_idx == DATA_POINTS-1).
REQ-023 SHALL hold data_out, word_idx and last stable while rd_valid && !rd_ready.
REQ-024 SHALL wrap both pointers modulo DEPTH.
REQ-025 SHALL update fill_count +1 on accept, -1 on retire, and leave it unchanged on a simultaneous accept and retire; full = (fill_count == DEPTH), empty = (fill_count == 0).
REQ-026 SHALL refuse a write when full even if a retire occurs in the same cycle; the slot becomes writable the next cycle.
REQ-027 SHALL treat wr_valid && !wr_ready as an overflow event; the frame is dropped and storage is unchanged.

Reset
REQ-028 SHALL, while sclr_n = 0 at a clock edge, clear the pointers, word_idx, fill_count and overflow_count. Resulting outputs: empty=1, full=0, wr_ready=1, rd_valid=0, last=0, data_out=0.
REQ-029 SHALL discard all stored frames on a reset asserted mid-frame, including a partially read frame; frame storage contents need not be cleared.
REQ-030 SHALL ignore wr_valid and rd_ready in any cycle where sclr_n = 0.

Configuration
REQ-031 SHALL use macro SPECTRUM_FRAME_FIFO_OVERFLOW_CNT_EN.
- Defined: overflow_count increments by 1 per overflow event and saturates at 16'hFFFF.
- Undefined: overflow_count is tied to 0 and no counter logic is built.
- The port exists in both builds.

Verification (defaults WIDTH=9, DATA_POINTS=5, DEPTH_LOG2=3)
REQ-032 SHALL cover basic transfer: after reset, write {0C0,0FF,0EE,00F,0F0} with rd_ready=1.
- Next cycle: rd_valid=1.
- Over 5 cycles data_out = 0C0,0FF,0EE,00F,0F0, word_idx 0..4, last only on 0F0.
- Then empty=1, fill_count=0.
REQ-033 SHALL cover backpressure: same frame with rd_ready=0 for 4 cycles after word 1.
- data_out holds 0FF and word_idx holds 1 for those cycles.
- Remaining words follow in order once rd_ready=1.
REQ-034 SHALL cover fill and overflow: write 9 frames back-to-back with rd_ready=0.
- After 8 frames: full=1, fill_count=8, wr_ready=0.
- 9th frame dropped; overflow_count=1 with the macro, 0 without.
REQ-035 SHALL cover boundary read/write: from full, read 5 words while wr_valid=1 throughout.
- Write is refused on the cycle last is transferred.
- Write is accepted the next cycle; fill_count goes 8 -> 7 -> 8.
- Pointers wrap and read order is preserved.
REQ-036 SHALL cover mid-frame reset: sclr_n=0 for 1 cycle after 2 words of a frame are read.
- Next cycle: empty=1, word_idx=0, data_out=0, overflow_count=0.
- A new frame then reads from word 0.

Source files
------------

// File: rtl/spectrum_frame_fifo.sv
// -----------------------------------------------------------------------------
// spectrum_frame_fifo
//
// Frame-oriented FIFO for spectrum data. A whole frame of DATA_POINTS words
// is written in a single cycle. It is then read out one word per transfer,
// along with the word's index inside the frame and an end-of-frame flag.
// Occupancy is tracked in whole frames. A frame that is partially read out
// still counts as stored until its last word has been taken.
//
// Parameters
//   WIDTH        bits per data word
//   DATA_POINTS  words per frame (must be >= 2)
//   DEPTH_LOG2   log2 of the frame capacity (DEPTH = 2**DEPTH_LOG2)
//
// Ports
//   eth_clk         single clock; all logic runs on its rising edge
//   sclr_n          synchronous active-low reset
//   data_in         one full frame (unpacked array of DATA_POINTS words)
//   wr_valid        a frame is offered on data_in
//   wr_ready        a frame can be accepted (registered state only)
//   data_out        current output word (0 while empty)
//   word_idx        index of data_out within its frame
//   last            data_out is the final word of its frame
//   rd_valid        data_out is valid
//   rd_ready        consumer takes data_out this cycle
//   empty, full     frame-level status
//   fill_count      stored frames, including a partially read frame
//   overflow_count  dropped-frame counter
//
// Build option
//   SPECTRUM_FRAME_FIFO_OVERFLOW_CNT_EN
//     Defined:   overflow_count counts dropped frames and saturates at 16'hFFFF.
//     Undefined: overflow_count is tied to 0 and no counter is built.
// -----------------------------------------------------------------------------
module spectrum_frame_fifo #(
  parameter int WIDTH       = 9,
  parameter int DATA_POINTS = 5,
  parameter int DEPTH_LOG2  = 3
) (
  input  logic                           eth_clk,
  input  logic                           sclr_n,
  input  logic [WIDTH-1:0]               data_in [DATA_POINTS],
  input  logic                           wr_valid,
  output logic                           wr_ready,
  output logic [WIDTH-1:0]               data_out,
  output logic [$clog2(DATA_POINTS)-1:0] word_idx,
  output logic                           last,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic                           empty,
  output logic                           full,
  output logic [DEPTH_LOG2:0]            fill_count,
  output logic [15:0]                    overflow_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int IDX_W = $clog2(DATA_POINTS);

  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(DATA_POINTS - 1);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Frame storage. It is never cleared, because the pointers and the fill
  // count alone decide which entries hold live data.
  logic [WIDTH-1:0] frame_mem [DEPTH][DATA_POINTS];

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic accept;
  logic transfer;
  logic retire;

  // Status comes straight from the registered fill count. So wr_ready never
  // depends on rd_ready in the same cycle. A full FIFO refuses a write even
  // when a retire happens on that edge. The freed slot can be written from
  // the next cycle on.
  assign full     = (fill_count == FULL_COUNT);
  assign empty    = (fill_count == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;

  // Handshake qualifiers. Every handshake is masked while reset is held, so
  // wr_valid and rd_ready have no effect during a reset cycle.
  assign accept   = sclr_n && wr_valid && wr_ready;
  assign transfer = sclr_n && rd_valid && rd_ready;
  assign retire   = transfer && (word_idx == LAST_IDX);

  // The output word is selected combinationally from the head frame. It
  // stays stable under backpressure because word_idx and rd_ptr only move
  // on a transfer. The output is forced to zero when nothing is stored.
  assign last     = rd_valid && (word_idx == LAST_IDX);
  assign data_out = empty ? '0 : frame_mem[rd_ptr][word_idx];

  // Capture every word of an accepted frame at the write pointer at once.
  // This block has no reset, on purpose: storage contents do not matter
  // once the pointers have been cleared.
  always_ff @(posedge eth_clk) begin
    if (accept) begin
      for (int i = 0; i < DATA_POINTS; i++) begin
        frame_mem[wr_ptr][i] <= data_in[i];
      end
    end
  end

  // Write pointer. It moves once per accepted frame and wraps naturally,
  // because DEPTH is a power of two.
  always_ff @(posedge eth_clk) begin
    if (!sclr_n) begin
      wr_ptr <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read side. word_idx walks through the head frame, one step per transfer.
  // After the last word, word_idx returns to 0 and the read pointer moves
  // to the next frame. A reset in the middle of a frame throws away the
  // rest of that frame.
  always_ff @(posedge eth_clk) begin
    if (!sclr_n) begin
      rd_ptr   <= '0;
      word_idx <= '0;
    end else if (transfer) begin
      if (word_idx == LAST_IDX) begin
        word_idx <= '0;
        rd_ptr   <= rd_ptr + 1'b1;
      end else begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

  // Frame occupancy. It counts up on accept and down on retire, and it holds
  // its value when both happen on the same edge.
  always_ff @(posedge eth_clk) begin
    if (!sclr_n) begin
      fill_count <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   fill_count <= fill_count + 1'b1;
        2'b01:   fill_count <= fill_count - 1'b1;
        default: fill_count <= fill_count;
      endcase
    end
  end

`ifdef SPECTRUM_FRAME_FIFO_OVERFLOW_CNT_EN
  logic        overflow_event;
  logic [15:0] overflow_q;

  // An offered frame that cannot be taken is dropped and counted here.
  // Storage is left untouched in that case.
  assign overflow_event = sclr_n && wr_valid && !wr_ready;

  // Saturating dropped-frame counter. It sticks at all-ones instead of
  // wrapping, so a long overload never reads back as a small count.
  always_ff @(posedge eth_clk) begin
    if (!sclr_n) begin
      overflow_q <= '0;
    end else if (overflow_event && (overflow_q != 16'hFFFF)) begin
      overflow_q <= overflow_q + 16'd1;
    end
  end

  assign overflow_count = overflow_q;
`else
  // Counter not built. The port stays so that both builds share one interface.
  assign overflow_count = '0;
`endif

endmodule
